// File: rtl/delay_timer_pkg.sv
// Shared state encoding and elaboration helpers for the delay timer bank.
package delay_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } chState_t;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Minimum counter width able to hold 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/delay_timer_ch.sv
// One delay channel: IDLE/HOLD/DONE handshake FSM with tick counter and start-time capture.
// DELAY_EXACT_PHASE_EN gives the channel a private prescaler restarted on every start and reload.
module delay_timer_ch
    import delay_timer_pkg::*;
#(
    parameter int DIV   = 10,
    parameter int CNT_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_val,
    input  logic             i_periodic,
    output logic             o_fin,
    output logic             o_busy
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_HOLD = HOLD;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_val;
    logic             r_periodic;
    logic             r_finPulse;
    logic             w_tick;

`ifdef DELAY_EXACT_PHASE_EN
    localparam int PRE_W = clog2(DIV);

    logic [PRE_W-1:0] r_pre;
    logic             w_restart;
    logic             w_unusedTick;

    assign w_unusedTick = i_tick;
    assign w_tick       = (r_pre == PRE_W'(DIV - 1));
    assign w_restart    = ((r_state == S_IDLE) && i_en) ||
                          ((r_state == S_HOLD) && i_en && (r_cnt == r_val) && r_periodic);

    // Phase is anchored to the start (or reload) edge so every delay is exactly val*DIV+1 cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pre <= '0;
        end else if (w_restart || w_tick) begin
            r_pre <= '0;
        end else if (r_state == S_HOLD) begin
            r_pre <= r_pre + 1'b1;
        end
    end
`else
    localparam int unusedDiv = DIV;

    assign w_tick = i_tick;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_val      <= '0;
            r_periodic <= 1'b0;
            r_finPulse <= 1'b0;
        end else begin
            r_finPulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        r_val      <= i_val;
                        r_periodic <= i_periodic;
                        r_cnt      <= '0;
                        r_state    <= S_HOLD;
                    end
                end
                // Dropping enable wins over a coincident expiry, so an abort never reports a finish.
                S_HOLD: begin
                    if (!i_en) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == r_val) begin
                        if (r_periodic) begin
                            r_cnt      <= '0;
                            r_finPulse <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (w_tick) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!i_en) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fin  = ((r_state == S_DONE) && i_en) || r_finPulse;
    assign o_busy = (r_state == S_HOLD);

endmodule

// File: rtl/delay_timer_bank.sv
// Bank of NUM_CH programmable delay timers sharing one tick prescaler.
// Define DELAY_EXACT_PHASE_EN for per-channel exact-phase delays (TICK stays shared).
module delay_timer_bank
    import delay_timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int TICK_HZ     = 1000,
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CH-1:0]       i_delayEn,
    input  logic [NUM_CH*CNT_W-1:0] i_delayVal,
    input  logic [NUM_CH-1:0]       i_periodic,
    output logic [NUM_CH-1:0]       o_delayFin,
    output logic [NUM_CH-1:0]       o_busy,
    output logic                    o_tick
);

    localparam int DIV   = calc_div(CLK_FREQ_HZ, TICK_HZ);
    localparam int PRE_W = clog2(DIV);

    if ((CLK_FREQ_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_badDiv
        $error("delay_timer_bank: CLK_FREQ_HZ/TICK_HZ must be an integer of at least 2");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_badNumCh
        $error("delay_timer_bank: NUM_CH must be within 1..16");
    end

    logic [PRE_W-1:0] r_pre;
    logic             r_tick;

    // Registered tick: high for the one cycle following pre==DIV-1, giving an exact DIV-cycle period.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_pre == PRE_W'(DIV - 1));
            r_pre  <= (r_pre == PRE_W'(DIV - 1)) ? '0 : r_pre + 1'b1;
        end
    end

    assign o_tick = r_tick;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        delay_timer_ch #(
            .DIV   (DIV),
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_tick     (r_tick),
            .i_en       (i_delayEn[g]),
            .i_val      (i_delayVal[g*CNT_W +: CNT_W]),
            .i_periodic (i_periodic[g]),
            .o_fin      (o_delayFin[g]),
            .o_busy     (o_busy[g])
        );
    end

endmodule

// File: tb/tb_delay_timer_bank.sv
// Directed, scoreboard-based bench for delay_timer_bank (DIV=10, 4 channels); follows DELAY_EXACT_PHASE_EN.
module tb_delay_timer_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 12;
    localparam int DIV    = 10;

    logic                    clk;
    logic                    rstN;
    logic [NUM_CH-1:0]       delayEn;
    logic [NUM_CH*CNT_W-1:0] delayVal;
    logic [NUM_CH-1:0]       periodic;
    logic [NUM_CH-1:0]       delayFin;
    logic [NUM_CH-1:0]       busy;
    logic                    tick;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int resetEdge = 0;
    int expQ[$];

    delay_timer_bank #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (100),
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_delayEn  (delayEn),
        .i_delayVal (delayVal),
        .i_periodic (periodic),
        .o_delayFin (delayFin),
        .o_busy     (busy),
        .o_tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: the value seen at a negedge is the index of the edge just taken.
    always @(posedge clk) cyc <= cyc + 1;

    // Shared tick as sampled at edge e: high when e-1 is a positive multiple of DIV edges after reset.
    function automatic bit sharedTickAt(input int e);
        int k;
        k = e - 1 - resetEdge;
        return (k >= DIV) && ((k % DIV) == 0);
    endfunction

    function automatic bit chTickAt(input int e, input int epoch);
`ifdef DELAY_EXACT_PHASE_EN
        return (e > epoch) && (((e - epoch) % DIV) == 0);
`else
        return (e > epoch) && sharedTickAt(e);
`endif
    endfunction

    // Edge at which a delay of val ticks started (or reloaded) at edge epoch reports its finish.
    function automatic int nextFin(input int epoch, input int val);
        int e;
        int c;
        e = epoch;
        c = 0;
        while (c != val) begin
            e++;
            if (chTickAt(e, epoch)) c++;
        end
        return e + 1;
    endfunction

    task automatic applyStimulus(input int ch, input bit en, input int val, input bit per);
        delayEn[ch]                 = en;
        delayVal[ch*CNT_W +: CNT_W] = CNT_W'(val);
        periodic[ch]                = per;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitFin(input int ch, input int maxCyc, output int at);
        at = -1;
        for (int n = 0; n < maxCyc; n++) begin
            @(negedge clk);
            if (delayFin[ch]) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Holds a periodic channel enabled for nCyc edges and matches every FIN pulse against the model.
    task automatic runPeriodic(input int ch, input int val, input int nCyc, input string tag);
        int epoch;
        int e;
        int d;
        applyStimulus(ch, 1'b1, val, 1'b1);
        epoch = cyc + 1;
        e = epoch;
        d = nextFin(e, val);
        while (d <= epoch + nCyc - 1) begin
            expQ.push_back(d);
            e = d;
            d = nextFin(e, val);
        end
        for (int n = 0; n < nCyc; n++) begin
            @(negedge clk);
            checkOutput({tag, "_busy"}, int'(busy[ch]), 1);
            if (delayFin[ch]) checkOutput({tag, "_pulse"}, cyc, (expQ.size() > 0) ? expQ.pop_front() : -1);
        end
        checkOutput({tag, "_missing_pulses"}, expQ.size(), 0);
        expQ.delete();
        applyStimulus(ch, 1'b0, val, 1'b1);
        @(negedge clk);
        checkOutput({tag, "_idle"}, int'(busy[ch]), 0);
    endtask

    initial begin
        int epoch;
        int at;
        int seenFin;
        int gap;

        rstN     = 1'b0;
        delayEn  = '0;
        delayVal = '0;
        periodic = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_fin", int'(delayFin), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_tick", int'(tick), 0);
        rstN      = 1'b1;
        resetEdge = cyc;
        @(negedge clk);
        checkOutput("post_reset_fin", int'(delayFin), 0);
        checkOutput("post_reset_tick", int'(tick), 0);

        $display("[TB] one-shot ch0 val=3");
        applyStimulus(0, 1'b1, 3, 1'b0);
        epoch = cyc + 1;
        expQ.push_back(nextFin(epoch, 3));
        @(negedge clk);
        checkOutput("t1_busy", int'(busy[0]), 1);
        waitFin(0, 100, at);
        checkOutput("t1_fin_edge", at, expQ.pop_front());
        repeat (3) @(negedge clk);
        checkOutput("t1_fin_held", int'(delayFin[0]), 1);
        checkOutput("t1_done_not_busy", int'(busy[0]), 0);
        applyStimulus(0, 1'b0, 3, 1'b0);
        #1;
        checkOutput("t1_fin_drop_same_cycle", int'(delayFin[0]), 0);
        @(negedge clk);
        checkOutput("t1_idle_fin", int'(delayFin[0]), 0);

        $display("[TB] periodic ch1 val=2");
        runPeriodic(1, 2, 100, "t2");

        $display("[TB] abort and restart ch2");
        applyStimulus(2, 1'b1, 5, 1'b0);
        seenFin = 0;
        repeat (20) begin
            @(negedge clk);
            if (delayFin[2]) seenFin++;
        end
        checkOutput("t3_no_fin_in_hold", seenFin, 0);
        applyStimulus(2, 1'b0, 5, 1'b0);
        @(negedge clk);
        checkOutput("t3_abort_busy", int'(busy[2]), 0);
        checkOutput("t3_abort_fin", int'(delayFin[2]), 0);
        applyStimulus(2, 1'b1, 1, 1'b0);
        epoch = cyc + 1;
        expQ.push_back(nextFin(epoch, 1));
        waitFin(2, 60, at);
        checkOutput("t3_restart_fin_edge", at, expQ.pop_front());
        applyStimulus(2, 1'b0, 1, 1'b0);
        @(negedge clk);

        $display("[TB] reset while running");
        applyStimulus(0, 1'b1, 1, 1'b0);
        applyStimulus(1, 1'b1, 3, 1'b1);
        applyStimulus(2, 1'b1, 7, 1'b0);
        applyStimulus(3, 1'b1, 2, 1'b0);
        repeat (25) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("t4_rst_fin", int'(delayFin), 0);
        checkOutput("t4_rst_busy", int'(busy), 0);
        checkOutput("t4_rst_tick", int'(tick), 0);
        rstN      = 1'b1;
        resetEdge = cyc;
        epoch     = cyc + 1;
        @(negedge clk);
        checkOutput("t4_rerun_busy", int'(busy), 4'hF);
        checkOutput("t4_rerun_fin", int'(delayFin), 0);
        expQ.push_back(nextFin(epoch, 1));
        waitFin(0, 60, at);
        checkOutput("t4_ch0_fin_edge", at, expQ.pop_front());
        expQ.push_back(nextFin(epoch, 2));
        waitFin(3, 60, at);
        checkOutput("t4_ch3_fin_edge", at, expQ.pop_front());
        delayEn = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_all_idle", int'(busy), 0);

        $display("[TB] zero delay on ch3");
        applyStimulus(3, 1'b1, 0, 1'b0);
        epoch = cyc + 1;
        expQ.push_back(nextFin(epoch, 0));
        waitFin(3, 10, at);
        checkOutput("t5_zero_oneshot_edge", at, expQ.pop_front());
        applyStimulus(3, 1'b0, 0, 1'b0);
        @(negedge clk);
        runPeriodic(3, 0, 11, "t5_zero_periodic");

        $display("[TB] random start phase ch0 val=4");
        for (int run = 0; run < 50; run++) begin
            gap = int'($urandom_range(0, 9));
            repeat (gap) @(negedge clk);
            applyStimulus(0, 1'b1, 4, 1'b0);
            epoch = cyc + 1;
            expQ.push_back(nextFin(epoch, 4));
            waitFin(0, 60, at);
            checkOutput("t6_fin_edge", at, expQ.pop_front());
            checkOutput("t6_fin_window", int'((at - epoch >= 32) && (at - epoch <= 41)), 1);
            applyStimulus(0, 1'b0, 4, 1'b0);
            @(negedge clk);
        end
        repeat (30) begin
            @(negedge clk);
            checkOutput("t6_tick", int'(tick), int'(sharedTickAt(cyc + 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
